drp_adc_responder: RTL and testbench
====================================

// Module: drp_adc_responder
// PURPOSE
//  Responder end of the ADC DRP/conversion interface. Accepts CONVST, runs a
//  timed conversion with BUSY/EOC, and answers DEN/DWE register accesses with
//  DO/DRDY, just as the on-chip ADC macro does. It latches one of two sample
//  inputs, chosen by mux_sel, into the VP/VN result register (0x03).
//  Used as a drop-in stand-in for the ADC macro on boards and benches that have
//  an external ADC, and for closed-loop checks of the conversion sequencer.
// PARAMETERS
//  CONV_CYCLES   26       clk cycles BUSY stays high per conversion (>=1)
//  READ_LATENCY  2        clk cycles from DEN sample to DRDY pulse (>=1)
//  INIT_CFG0     16'h8203 reset value of config reg 0x40
//  INIT_CFG1     16'h313F reset value of config reg 0x41
//  INIT_CFG2     16'h0A00 reset value of config reg 0x42
// PORTS
//  clk          in   1   system clock; all logic on its rising edge
//  rst          in   1   synchronous, active-high reset
//  convst       in   1   conversion start request, level sampled each clk
//  mux_sel      in   1   0: sample_a_in, 1: sample_b_in, sampled at conversion end
//  sample_a_in  in   12  unsigned sample, channel A
//  sample_b_in  in   12  unsigned sample, channel B
//  den          in   1   DRP access strobe, one-cycle pulse
//  dwe          in   1   write enable, qualified by den
//  daddr        in   7   register address, qualified by den
//  di           in   16  write data, qualified by den & dwe
//  do_out       out  16  read data, valid only while drdy=1, else 16'h0000
//  drdy         out  1   one-cycle access-complete pulse
//  busy         out  1   high while a conversion is in progress
//  eoc          out  1   one-cycle end-of-conversion pulse
// BEHAVIOUR
//  Reset: do_out=0, drdy=0, busy=0, eoc=0, reg03=0, status=0,
//   cfg0..2=INIT_CFG0..2, both FSMs idle. Reset mid-operation aborts both
//   transactions; no drdy or eoc pulse is issued for the aborted work.
//  Conversion FSM: C_IDLE -> C_BUSY -> C_EOC -> C_IDLE.
//   C_IDLE: convst=1 -> C_BUSY, busy=1 on the next cycle, counter loaded.
//   C_BUSY: busy stays high for exactly CONV_CYCLES cycles; on the final
//    cycle reg03 <= {sel_sample,4'b0}, and the FSM moves to C_EOC.
//   C_EOC: eoc=1 for one cycle, busy=0; return to C_IDLE. convst seen here
//    is accepted next cycle in C_IDLE.
//   convst=1 while in C_BUSY is ignored and sets status[0] (conv overrun).
//  DRP FSM: D_IDLE -> D_WAIT -> D_IDLE.
//   D_IDLE: den=1 captures daddr/dwe/di and loads the latency counter.
//   drdy pulses exactly READ_LATENCY cycles after the den cycle.
//   Read: do_out = register value at the drdy edge. Unmapped address -> 0.
//   Write: applied on the drdy edge to 0x40..0x42 only; other addresses are
//    dropped. do_out=0 on write completion.
//   den=1 while in D_WAIT is ignored, no extra drdy, and sets status[1]
//    (protocol error).
//  Register map (16b): 0x03 result (RO); 0x3F status {14'b0,err,ovr}
//   (RO, cleared on the drdy of its own read); 0x40..0x42 cfg (RW).
//  Simultaneous events: if reg03 updates on the same edge a read of 0x03
//   completes, the read returns the old value. If a status bit sets on
//   the same edge as a status clear-on-read, the set wins.
//  The two FSMs run independently; a DRP access may overlap a conversion.
// STRUCTURE
//  Package drp_adc_pkg: address constants (ADDR_VPVN=7'h03,
//   ADDR_STATUS=7'h3F, ADDR_CFG0..2=7'h40..42), C_*/D_* state encodings.
//  One sub-module: drp_adc_conv_engine (conversion FSM, busy/eoc, reg03,
//   overrun flag). The top level holds the DRP FSM and the register map.
// TESTING
//  1 reset; convst pulse, mux_sel=0, a=12'hABC -> busy high 26 cyc, eoc 1 cyc,
//    read 0x03 -> DRDY 2 cyc after den, do_out=16'hABC0.
//  2 mux_sel=1, b=12'h123, convst -> read 0x03 = 16'h1230; status reads 0.
//  3 write 0x41=16'h1234, read 0x41 -> 16'h1234; write 0x10=FFFF, read -> 0.
//  4 convst held high through busy -> status=16'h0001 on read, 0 on re-read;
//    the next conversion starts the cycle after eoc.
//  5 den on two consecutive cycles -> exactly one drdy; status bit1=1.
//  6 rst mid-conversion and mid-read -> no eoc/drdy; regs at INIT values.

Source files
------------

// File: rtl/drp_adc_pkg.sv
// Shared address map, FSM encodings and result formatting for the DRP ADC responder.
package drp_adc_pkg;

  localparam logic [6:0] ADDR_VPVN   = 7'h03;
  localparam logic [6:0] ADDR_STATUS = 7'h3F;
  localparam logic [6:0] ADDR_CFG0   = 7'h40;
  localparam logic [6:0] ADDR_CFG1   = 7'h41;
  localparam logic [6:0] ADDR_CFG2   = 7'h42;

  typedef enum logic [1:0] {
    C_IDLE = 2'd0,
    C_BUSY = 2'd1,
    C_EOC  = 2'd2
  } conv_state_e;

  typedef enum logic {
    D_IDLE = 1'b0,
    D_WAIT = 1'b1
  } drp_state_e;

  // 12-bit samples are left-justified in the 16-bit result word.
  function automatic logic [15:0] vpvn_word(input logic [11:0] sample);
    return {sample, 4'b0000};
  endfunction

endpackage

// File: rtl/drp_adc_conv_engine.sv
// Conversion sequencer: timed BUSY window, one-cycle EOC, result latch and overrun flag.
module drp_adc_conv_engine
  import drp_adc_pkg::*;
#(
  parameter int CONV_CYCLES = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        convst,
  input  logic        mux_sel,
  input  logic [11:0] sample_a_in,
  input  logic [11:0] sample_b_in,
  input  logic        ovr_clr,
  output logic        busy,
  output logic        eoc,
  output logic [15:0] reg03,
  output logic        ovr
);

  localparam int CW = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;

  conv_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   reg03_q, reg03_d;
  logic          ovr_q, ovr_d;
  logic          ovr_set;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    reg03_d = reg03_q;
    ovr_set = 1'b0;
    case (state_q)
      C_IDLE: begin
        if (convst) begin
          state_d = C_BUSY;
          cnt_d   = CW'(CONV_CYCLES - 1);
        end
      end
      C_BUSY: begin
        ovr_set = convst;
        if (cnt_q == '0) begin
          state_d = C_EOC;
          reg03_d = vpvn_word(mux_sel ? sample_b_in : sample_a_in);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      C_EOC:   state_d = C_IDLE;
      default: state_d = C_IDLE;
    endcase
    // A new overrun on the clearing edge must not be lost, so set dominates.
    ovr_d = (ovr_q & ~ovr_clr) | ovr_set;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= C_IDLE;
      cnt_q   <= '0;
      reg03_q <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      reg03_q <= reg03_d;
      ovr_q   <= ovr_d;
    end
  end

  assign busy  = (state_q == C_BUSY);
  assign eoc   = (state_q == C_EOC);
  assign reg03 = reg03_q;
  assign ovr   = ovr_q;

endmodule

// File: rtl/drp_adc_responder.sv
// ADC macro stand-in: DRP register access FSM and register map around the conversion engine.
module drp_adc_responder
  import drp_adc_pkg::*;
#(
  parameter int          CONV_CYCLES  = 26,
  parameter int          READ_LATENCY = 2,
  parameter logic [15:0] INIT_CFG0    = 16'h8203,
  parameter logic [15:0] INIT_CFG1    = 16'h313F,
  parameter logic [15:0] INIT_CFG2    = 16'h0A00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        convst,
  input  logic        mux_sel,
  input  logic [11:0] sample_a_in,
  input  logic [11:0] sample_b_in,
  input  logic        den,
  input  logic        dwe,
  input  logic [6:0]  daddr,
  input  logic [15:0] di,
  output logic [15:0] do_out,
  output logic        drdy,
  output logic        busy,
  output logic        eoc
);

  localparam int LW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  drp_state_e  d_state_q, d_state_d;
  logic [LW-1:0] d_cnt_q, d_cnt_d;
  logic [6:0]  addr_q, addr_d;
  logic        dwe_q, dwe_d;
  logic [15:0] di_q, di_d;
  logic [15:0] cfg0_q, cfg0_d, cfg1_q, cfg1_d, cfg2_q, cfg2_d;
  logic        err_q, err_d;
  logic [15:0] reg03;
  logic        ovr;
  logic        status_clr;
  logic [15:0] rd_data;

  drp_adc_conv_engine #(
    .CONV_CYCLES (CONV_CYCLES)
  ) u_conv (
    .clk         (clk),
    .rst         (rst),
    .convst      (convst),
    .mux_sel     (mux_sel),
    .sample_a_in (sample_a_in),
    .sample_b_in (sample_b_in),
    .ovr_clr     (status_clr),
    .busy        (busy),
    .eoc         (eoc),
    .reg03       (reg03),
    .ovr         (ovr)
  );

  always_comb begin
    d_state_d = d_state_q;
    d_cnt_d   = d_cnt_q;
    addr_d    = addr_q;
    dwe_d     = dwe_q;
    di_d      = di_q;
    cfg0_d    = cfg0_q;
    cfg1_d    = cfg1_q;
    cfg2_d    = cfg2_q;

    // drdy is decoded from state so it lands exactly READ_LATENCY cycles after den.
    drdy = (d_state_q == D_WAIT) && (d_cnt_q == '0);

    case (addr_q)
      ADDR_VPVN:   rd_data = reg03;
      ADDR_STATUS: rd_data = {14'b0, err_q, ovr};
      ADDR_CFG0:   rd_data = cfg0_q;
      ADDR_CFG1:   rd_data = cfg1_q;
      ADDR_CFG2:   rd_data = cfg2_q;
      default:     rd_data = '0;
    endcase

    do_out     = (drdy && !dwe_q) ? rd_data : '0;
    status_clr = drdy && !dwe_q && (addr_q == ADDR_STATUS);
    err_d      = (err_q & ~status_clr) | (den && (d_state_q == D_WAIT));

    case (d_state_q)
      D_IDLE: begin
        if (den) begin
          d_state_d = D_WAIT;
          d_cnt_d   = LW'(READ_LATENCY - 1);
          addr_d    = daddr;
          dwe_d     = dwe;
          di_d      = di;
        end
      end
      D_WAIT: begin
        if (d_cnt_q == '0) begin
          d_state_d = D_IDLE;
          if (dwe_q) begin
            case (addr_q)
              ADDR_CFG0: cfg0_d = di_q;
              ADDR_CFG1: cfg1_d = di_q;
              ADDR_CFG2: cfg2_d = di_q;
              default:   ;
            endcase
          end
        end else begin
          d_cnt_d = d_cnt_q - LW'(1);
        end
      end
      default: d_state_d = D_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_state_q <= D_IDLE;
      d_cnt_q   <= '0;
      addr_q    <= '0;
      dwe_q     <= 1'b0;
      di_q      <= '0;
      cfg0_q    <= INIT_CFG0;
      cfg1_q    <= INIT_CFG1;
      cfg2_q    <= INIT_CFG2;
      err_q     <= 1'b0;
    end else begin
      d_state_q <= d_state_d;
      d_cnt_q   <= d_cnt_d;
      addr_q    <= addr_d;
      dwe_q     <= dwe_d;
      di_q      <= di_d;
      cfg0_q    <= cfg0_d;
      cfg1_q    <= cfg1_d;
      cfg2_q    <= cfg2_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_drp_adc_responder.sv
// Scoreboard bench: DRP accesses queue expected data/arrival cycle; a negedge monitor checks every drdy.
module tb_drp_adc_responder;

  localparam int CONV_CYCLES  = 26;
  localparam int READ_LATENCY = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        convst = 1'b0;
  logic        mux_sel = 1'b0;
  logic [11:0] sample_a_in = '0;
  logic [11:0] sample_b_in = '0;
  logic        den = 1'b0;
  logic        dwe = 1'b0;
  logic [6:0]  daddr = '0;
  logic [15:0] di = '0;
  logic [15:0] do_out;
  logic        drdy;
  logic        busy;
  logic        eoc;

  drp_adc_responder #(
    .CONV_CYCLES  (CONV_CYCLES),
    .READ_LATENCY (READ_LATENCY),
    .INIT_CFG0    (16'h8203),
    .INIT_CFG1    (16'h313F),
    .INIT_CFG2    (16'h0A00)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .convst      (convst),
    .mux_sel     (mux_sel),
    .sample_a_in (sample_a_in),
    .sample_b_in (sample_b_in),
    .den         (den),
    .dwe         (dwe),
    .daddr       (daddr),
    .di          (di),
    .do_out      (do_out),
    .drdy        (drdy),
    .busy        (busy),
    .eoc         (eoc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    int          due;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc     = 0;
  int   checks  = 0;
  int   errors  = 0;
  int   eoc_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every drdy must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (eoc) eoc_cnt++;
    if (drdy) begin
      if (sb.size() == 0) begin
        check("drdy_spurious", 1, 0);
      end else begin
        e = sb.pop_front();
        check({e.name, "_data"}, do_out, e.data);
        check({e.name, "_latency"}, cyc, e.due);
      end
    end else if (do_out !== 16'h0000) begin
      check("do_out_idle", do_out, 16'h0000);
    end
  end

  task automatic drp(input logic we, input logic [6:0] a, input logic [15:0] d,
                     input logic [15:0] exp, input string nm);
    exp_t e;
    @(posedge clk); #1;
    den = 1'b1; dwe = we; daddr = a; di = d;
    e.data = exp; e.due = cyc + READ_LATENCY; e.name = nm;
    sb.push_back(e);
    @(posedge clk); #1;
    den = 1'b0; dwe = 1'b0;
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      check({nm, "_timeout"}, 1, 0);
      sb.delete();
    end
  endtask

  // Waits for eoc counting busy cycles; returns in the eoc cycle (at its negedge).
  task automatic wait_eoc(input string nm, input int exp_busy);
    int nb = 0;
    bit done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (busy) nb++;
      if (eoc) done = 1;
    end
    check({nm, "_eoc_seen"}, done, 1);
    check({nm, "_busy_len"}, nb, exp_busy);
    check({nm, "_busy_at_eoc"}, busy, 0);
  endtask

  task automatic conv_pulse(input string nm, input logic sel, input logic [11:0] a,
                            input logic [11:0] b);
    mux_sel = sel; sample_a_in = a; sample_b_in = b;
    @(posedge clk); #1 convst = 1'b1;
    @(posedge clk); #1 convst = 1'b0;
    wait_eoc(nm, CONV_CYCLES);
    @(negedge clk);
    check({nm, "_eoc_width"}, eoc, 0);
  endtask

  initial begin
    int ev;
    // 1: reset state, channel A conversion and result readback
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_do_out", do_out, 16'h0000);
    check("rst_drdy", drdy, 0);
    check("rst_busy", busy, 0);
    check("rst_eoc", eoc, 0);
    @(posedge clk); #1 rst = 1'b0;

    conv_pulse("conv_a", 1'b0, 12'hABC, 12'h000);
    drp(1'b0, 7'h03, 16'h0, 16'hABC0, "rd_vpvn_a");

    // 2: channel B, status clean after single-cycle convst
    conv_pulse("conv_b", 1'b1, 12'hFFF, 12'h123);
    drp(1'b0, 7'h03, 16'h0, 16'h1230, "rd_vpvn_b");
    drp(1'b0, 7'h3F, 16'h0, 16'h0000, "rd_status_clean");

    // 3: config write/read, unmapped and read-only addresses
    drp(1'b1, 7'h41, 16'h1234, 16'h0000, "wr_cfg1");
    drp(1'b0, 7'h41, 16'h0, 16'h1234, "rd_cfg1");
    drp(1'b1, 7'h10, 16'hFFFF, 16'h0000, "wr_unmapped");
    drp(1'b0, 7'h10, 16'h0, 16'h0000, "rd_unmapped");
    drp(1'b1, 7'h03, 16'hFFFF, 16'h0000, "wr_vpvn_ro");
    drp(1'b0, 7'h03, 16'h0, 16'h1230, "rd_vpvn_ro");

    // 4: convst held through busy -> overrun, back-to-back restart after eoc
    mux_sel = 1'b0; sample_a_in = 12'h5A5; sample_b_in = 12'h000;
    @(posedge clk); #1 convst = 1'b1;
    wait_eoc("conv_hold", CONV_CYCLES);
    @(negedge clk);
    check("hold_idle_after_eoc", busy, 0);
    @(posedge clk); #1 convst = 1'b0;
    @(negedge clk);
    check("hold_restart_busy", busy, 1);
    wait_eoc("conv_hold2", CONV_CYCLES - 1);
    drp(1'b0, 7'h3F, 16'h0, 16'h0001, "rd_status_ovr");
    drp(1'b0, 7'h3F, 16'h0, 16'h0000, "rd_status_ovr_clr");
    drp(1'b0, 7'h03, 16'h0, 16'h5A50, "rd_vpvn_hold");

    // 5: den on two consecutive cycles -> one drdy, protocol error flag
    begin
      exp_t e;
      @(posedge clk); #1;
      den = 1'b1; dwe = 1'b0; daddr = 7'h42;
      e.data = 16'h0A00; e.due = cyc + READ_LATENCY; e.name = "rd_cfg2_dbl";
      sb.push_back(e);
      @(posedge clk); #1;
      @(posedge clk); #1 den = 1'b0;
      for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
      check("dbl_den_done", sb.size(), 0);
      sb.delete();
      repeat (4) @(negedge clk);
    end
    drp(1'b0, 7'h3F, 16'h0, 16'h0002, "rd_status_err");
    drp(1'b0, 7'h3F, 16'h0, 16'h0000, "rd_status_err_clr");

    // 6: reset in the middle of a conversion and a read
    mux_sel = 1'b0; sample_a_in = 12'h777;
    @(posedge clk); #1 convst = 1'b1;
    @(posedge clk); #1 convst = 1'b0;
    repeat (5) @(posedge clk);
    #1 den = 1'b1; dwe = 1'b0; daddr = 7'h41;
    @(posedge clk); #1 den = 1'b0; rst = 1'b1;
    ev = eoc_cnt;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (40) @(negedge clk);
    check("rst_abort_no_eoc", eoc_cnt, ev);
    check("rst_abort_busy", busy, 0);
    drp(1'b0, 7'h40, 16'h0, 16'h8203, "rd_cfg0_init");
    drp(1'b0, 7'h41, 16'h0, 16'h313F, "rd_cfg1_init");
    drp(1'b0, 7'h42, 16'h0, 16'h0A00, "rd_cfg2_init");
    drp(1'b0, 7'h03, 16'h0, 16'h0000, "rd_vpvn_init");
    drp(1'b0, 7'h3F, 16'h0, 16'h0000, "rd_status_init");

    repeat (5) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
